// File: rtl/deconv_col_packer_if.sv
// Column-in / beat-out bundle for deconv_col_packer.
// The master modport is the packer's view (it masters the output beat stream);
// the slave modport is the view of whoever feeds columns and sinks beats.
interface deconv_col_packer_if #(
  parameter int PIX_WIDTH = 8,
  parameter int N_PIX_OUT = 19,
  parameter int BEAT_PIX  = 4
);
  logic                              col_valid_i;
  logic [2*PIX_WIDTH*N_PIX_OUT-1:0]  col_data_i;
  logic [3:0]                        cfg_shift_i;
  logic                              cfg_relu_i;
  logic                              m_valid_o;
  logic                              m_ready_i;
  logic [BEAT_PIX*PIX_WIDTH-1:0]     m_data_o;
  logic [BEAT_PIX-1:0]               m_keep_o;
  logic                              m_last_o;
  logic                              frame_done_o;
  logic                              overflow_o;
  logic                              ovf_clr_i;

  modport master (
    input  col_valid_i, col_data_i, cfg_shift_i, cfg_relu_i, m_ready_i, ovf_clr_i,
    output m_valid_o, m_data_o, m_keep_o, m_last_o, frame_done_o, overflow_o
  );

  modport slave (
    output col_valid_i, col_data_i, cfg_shift_i, cfg_relu_i, m_ready_i, ovf_clr_i,
    input  m_valid_o, m_data_o, m_keep_o, m_last_o, frame_done_o, overflow_o
  );
endinterface

// File: rtl/deconv_col_packer.sv
// Requantises finished deconvolution columns, buffers up to two of them and
// streams each one out as BEAT_PIX-pixel beats.
//
//  state  | meaning
//  IDLE   | no column in flight, waiting for a buffered or arriving column
//  LOAD   | one cycle: point at the oldest entry, clear the beat counter
//  SEND   | present beats; advance on handshake, release entry on last beat
module deconv_col_packer #(
  parameter int PIX_WIDTH = 8,
  parameter int N_PIX_OUT = 19,
  parameter int BEAT_PIX  = 4
) (
  input logic                  clk,
  input logic                  rst,
  deconv_col_packer_if.master  bus
);

  localparam int LANE_W  = 2 * PIX_WIDTH;
  localparam int COL_W   = PIX_WIDTH * N_PIX_OUT;
  localparam int BEAT_W  = PIX_WIDTH * BEAT_PIX;
  localparam int N_BEATS = (N_PIX_OUT + BEAT_PIX - 1) / BEAT_PIX;
  localparam int PAD_W   = N_BEATS * BEAT_W;
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int CW      = (N_PIX_OUT > 1) ? $clog2(N_PIX_OUT) : 1;
  localparam int REM     = N_PIX_OUT % BEAT_PIX;

  localparam logic [BEAT_PIX-1:0] LAST_KEEP =
    (REM == 0) ? {BEAT_PIX{1'b1}} : BEAT_PIX'((1 << REM) - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(N_PIX_OUT - 1);

  localparam logic signed [LANE_W:0] PIX_MAX = (LANE_W+1)'((1 << (PIX_WIDTH-1)) - 1);
  localparam logic signed [LANE_W:0] PIX_MIN = -PIX_MAX - (LANE_W+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  // Round-half-up arithmetic shift, saturate, optional ReLU. One guard bit
  // keeps the rounding add from wrapping at the top of the lane range.
  function automatic logic [PIX_WIDTH-1:0] requant(
    input logic signed [LANE_W-1:0] x,
    input logic [3:0]               sh,
    input logic                     relu
  );
    logic signed [LANE_W:0] ext;
    logic signed [LANE_W:0] shf;
    logic [PIX_WIDTH-1:0]   pix;
    ext = {x[LANE_W-1], x};
    if (sh != 4'd0) ext = ext + ((LANE_W+1)'(1) << (sh - 4'd1));
    shf = ext >>> sh;
    if (shf > PIX_MAX)      pix = PIX_MAX[PIX_WIDTH-1:0];
    else if (shf < PIX_MIN) pix = PIX_MIN[PIX_WIDTH-1:0];
    else                    pix = shf[PIX_WIDTH-1:0];
    if (relu && pix[PIX_WIDTH-1]) pix = '0;
    return pix;
  endfunction

  logic [1:0]       state;
  logic [COL_W-1:0] col_buf [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic [BW-1:0]    beat;
  logic [CW-1:0]    col_cnt;
  logic             frame_done, overflow;
  logic [COL_W-1:0] q_col;
  logic [PAD_W-1:0] padded;
  logic             fire, last_fire, accept, drop;

  // Requantise every lane of the incoming column with the cfg of this pulse,
  // so buffered columns are immune to later cfg changes.
  always_comb begin
    q_col = '0;
    for (int i = 0; i < N_PIX_OUT; i++)
      q_col[i*PIX_WIDTH +: PIX_WIDTH] =
        requant(bus.col_data_i[i*LANE_W +: LANE_W], bus.cfg_shift_i, bus.cfg_relu_i);
  end

  // Handshake decode; an entry freed by the last beat can take a new column
  // in the same cycle.
  always_comb begin
    fire      = (state == S_SEND) && bus.m_ready_i;
    last_fire = fire && (beat == LAST_BEAT);
    accept    = bus.col_valid_i && ((count != 2'd2) || last_fire);
    drop      = bus.col_valid_i && !accept;
  end

  // Column storage; occupancy is tracked by count, so data needs no reset.
  always_ff @(posedge clk) begin
    if (accept) col_buf[wr_ptr] <= q_col;
  end

  // Two-entry FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept)    wr_ptr <= ~wr_ptr;
      if (last_fire) rd_ptr <= ~rd_ptr;
      case ({accept, last_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer: IDLE -> LOAD -> SEND -> LOAD/IDLE, plus beat counter.
  // IDLE reacts to the arriving pulse directly so the first beat lands at t+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept || count != 2'd0) state <= S_LOAD;
        S_LOAD: begin
          beat  <= '0;
          state <= S_SEND;
        end
        S_SEND: if (fire) begin
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= (count == 2'd2 || accept) ? S_LOAD : S_IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Column-in-frame counter, frame pulse and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= last_fire && (col_cnt == LAST_COL);
      if (last_fire) col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
      if (drop)               overflow <= 1'b1;
      else if (bus.ovf_clr_i) overflow <= 1'b0;
    end
  end

  // Beat mux straight off the held entry: stable under backpressure, and
  // forced to zero outside SEND so reset clears the bus immediately.
  always_comb begin
    padded        = PAD_W'(col_buf[rd_ptr]);
    bus.m_valid_o = (state == S_SEND);
    bus.m_data_o  = '0;
    bus.m_keep_o  = '0;
    bus.m_last_o  = 1'b0;
    if (state == S_SEND) begin
      for (int b = 0; b < N_BEATS; b++)
        if (beat == BW'(b)) bus.m_data_o = padded[b*BEAT_W +: BEAT_W];
      bus.m_last_o = (beat == LAST_BEAT);
      bus.m_keep_o = (beat == LAST_BEAT) ? LAST_KEEP : {BEAT_PIX{1'b1}};
    end
  end

  assign bus.frame_done_o = frame_done;
  assign bus.overflow_o   = overflow;

endmodule

// File: tb/tb_deconv_col_packer.sv
// Scoreboard bench for deconv_col_packer: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_deconv_col_packer;
  localparam int PW = 8;
  localparam int N  = 19;
  localparam int B  = 4;

  typedef logic [15:0] lane_arr_t [N];
  typedef logic [7:0]  pix_arr_t  [N];
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deconv_col_packer_if #(.PIX_WIDTH(PW), .N_PIX_OUT(N), .BEAT_PIX(B)) bus ();
  deconv_col_packer #(.PIX_WIDTH(PW), .N_PIX_OUT(N), .BEAT_PIX(B)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  beat_t exp_q [$];
  int    fd_q  [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    hs_total = 0;
  logic  hold_pend = 1'b0;
  beat_t hold_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_col(input pix_arr_t pix);
    beat_t bt;
    for (int b = 0; b < 5; b++) begin
      bt = '0;
      for (int j = 0; j < B; j++) begin
        int idx;
        idx = b * B + j;
        if (idx < N) begin
          bt.data[j*PW +: PW] = pix[idx];
          bt.keep[j] = 1'b1;
        end
      end
      bt.last = (b == 4);
      exp_q.push_back(bt);
    end
  endtask

  // Pulse col_valid for one cycle, then scramble data/cfg so only the
  // sampled values can matter.
  task automatic send_col(input lane_arr_t lanes, input logic [3:0] sh, input logic relu);
    for (int i = 0; i < N; i++) bus.col_data_i[i*16 +: 16] = lanes[i];
    bus.cfg_shift_i = sh;
    bus.cfg_relu_i  = relu;
    bus.col_valid_i = 1'b1;
    tick();
    bus.col_valid_i = 1'b0;
    bus.col_data_i  = '1;
    bus.cfg_shift_i = 4'hF;
    bus.cfg_relu_i  = ~relu;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, bus.m_valid_o, 0);
    check({tag, "_data"},  bus.m_data_o, 0);
    check({tag, "_keep"},  bus.m_keep_o, 0);
    check({tag, "_last"},  bus.m_last_o, 0);
    check({tag, "_fdone"}, bus.frame_done_o, 0);
    check({tag, "_ovf"},   bus.overflow_o, 0);
  endtask

  function automatic lane_arr_t lanes_fill(input logic [15:0] v);
    lane_arr_t l;
    for (int i = 0; i < N; i++) l[i] = v;
    return l;
  endfunction

  function automatic pix_arr_t pix_fill(input logic [7:0] v);
    pix_arr_t p;
    for (int i = 0; i < N; i++) p[i] = v;
    return p;
  endfunction

  // Monitor: hold check under backpressure, scoreboard pop on handshake.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur.data = bus.m_data_o;
    cur.keep = bus.m_keep_o;
    cur.last = bus.m_last_o;
    if (hold_pend) begin
      check("hold_valid", bus.m_valid_o, 1);
      check("hold_beat", cur, hold_beat);
    end
    if (bus.m_valid_o && bus.m_ready_i) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h keep %b last %b, required no beat",
                 cur.data, cur.keep, cur.last);
      end else begin
        e = exp_q.pop_front();
        check("beat", cur, e);
      end
    end
    if (bus.frame_done_o) fd_q.push_back(hs_total);
    hold_pend = bus.m_valid_o && !bus.m_ready_i && !rst;
    hold_beat = cur;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    lane_arr_t l;
    pix_arr_t  p, q;
    int        n;

    rst = 1'b1;
    bus.col_valid_i = 1'b0;
    bus.col_data_i  = '0;
    bus.cfg_shift_i = 4'd0;
    bus.cfg_relu_i  = 1'b0;
    bus.m_ready_i   = 1'b0;
    bus.ovf_clr_i   = 1'b0;
    #12;
    check_outputs_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // 0x0100 >> 4 -> 0x10 everywhere; latency and burst shape.
    bus.m_ready_i = 1'b1;
    push_col(pix_fill(8'h10));
    send_col(lanes_fill(16'h0100), 4'd4, 1'b0);
    check("lat_t1_valid", bus.m_valid_o, 0);
    tick();
    check("lat_t2_valid", bus.m_valid_o, 1);
    check("lat_t2_data", bus.m_data_o, 32'h10101010);
    check("lat_t2_keep", bus.m_keep_o, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("burst_valid", bus.m_valid_o, 1);
    end
    tick();
    check("t6_last", bus.m_last_o, 1);
    check("t6_keep", bus.m_keep_o, 4'b0111);
    check("t6_data", bus.m_data_o, 32'h00101010);
    tick();
    check("t7_idle", bus.m_valid_o, 0);
    drain(20);

    // Saturation with shift 3, without and with ReLU, back-to-back pulses.
    for (int i = 0; i < N; i++) begin
      case (i % 3)
        0: begin l[i] = 16'h7FFF; p[i] = 8'h7F; q[i] = 8'h7F; end
        1: begin l[i] = 16'h8000; p[i] = 8'h80; q[i] = 8'h00; end
        default: begin l[i] = 16'hFFF8; p[i] = 8'hFF; q[i] = 8'h00; end
      endcase
    end
    push_col(p);
    push_col(q);
    send_col(l, 4'd3, 1'b0);
    send_col(l, 4'd3, 1'b1);
    drain(40);
    check("sat_no_ovf", bus.overflow_o, 0);

    // Ramp column with a 3-cycle stall in the middle (beat 3 held).
    for (int i = 0; i < N; i++) begin
      l[i] = 16'(i * 16);
      p[i] = 8'(i * 4);
    end
    bus.m_ready_i = 1'b0;
    push_col(p);
    send_col(l, 4'd2, 1'b0);
    tick();
    check("stall_valid_up", bus.m_valid_o, 1);
    bus.m_ready_i = 1'b1;
    tick();
    tick();
    bus.m_ready_i = 1'b0;
    tick();
    tick();
    tick();
    check("stall_beat_data", bus.m_data_o, 32'h2C282420);
    bus.m_ready_i = 1'b1;
    drain(20);

    // Overflow: pulses two cycles apart into a stalled sink.
    bus.m_ready_i = 1'b0;
    push_col(pix_fill(8'h01));
    send_col(lanes_fill(16'h0010), 4'd4, 1'b0);
    tick();
    push_col(pix_fill(8'h02));
    send_col(lanes_fill(16'h0020), 4'd4, 1'b0);
    tick();
    check("ovf_before_drop", bus.overflow_o, 0);
    send_col(lanes_fill(16'h0030), 4'd4, 1'b0);
    check("ovf_set", bus.overflow_o, 1);
    tick();
    tick();
    check("ovf_sticky", bus.overflow_o, 1);
    bus.ovf_clr_i = 1'b1;
    send_col(lanes_fill(16'h0040), 4'd4, 1'b0);
    bus.ovf_clr_i = 1'b0;
    check("ovf_clr_vs_new", bus.overflow_o, 1);
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.ovf_clr_i = 1'b0;
    check("ovf_cleared", bus.overflow_o, 0);
    bus.m_ready_i = 1'b1;
    drain(40);
    tick();
    tick();
    check("ovf_two_cols_only", bus.m_valid_o, 0);

    // Release and arrival in the same cycle with both entries full.
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      l[i] = (i % 2 == 0) ? 16'h0005 : 16'hFFFE;
      p[i] = (i % 2 == 0) ? 8'h05 : 8'hFE;
    end
    push_col(p);
    send_col(l, 4'd0, 1'b0);
    push_col(pix_fill(8'h7F));
    send_col(lanes_fill(16'h0100), 4'd0, 1'b0);
    tick();
    bus.m_ready_i = 1'b1;
    n = 0;
    while (!(bus.m_valid_o && bus.m_last_o) && n < 40) begin
      tick();
      n++;
    end
    check("found_last_beat", bus.m_last_o, 1);
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: begin l[i] = 16'h0018; p[i] = 8'h02; end
        1: begin l[i] = 16'hFFE8; p[i] = 8'hFF; end
        2: begin l[i] = 16'h0007; p[i] = 8'h00; end
        default: begin l[i] = 16'hFFC0; p[i] = 8'hFC; end
      endcase
    end
    push_col(p);
    send_col(l, 4'd4, 1'b0);
    check("same_cycle_no_drop", bus.overflow_o, 0);
    drain(60);

    // Reset in the middle of beat 3, then a full column afterwards.
    push_col(pix_fill(8'h10));
    send_col(lanes_fill(16'h0100), 4'd4, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    tick();
    check_outputs_zero("midrst_hold");
    rst = 1'b0;
    tick();
    hs_total = 0;
    push_col(pix_fill(8'h10));
    send_col(lanes_fill(16'h0100), 4'd4, 1'b0);
    drain(20);
    tick();
    check("post_rst_beats", hs_total, 5);

    // Two frames of 19 back-to-back columns; frame_done after beats 95 and 190.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hs_total = 0;
    fd_q.delete();
    bus.m_ready_i = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      push_col(pix_fill(8'(c)));
      send_col(lanes_fill(16'(c * 16)), 4'd4, 1'b0);
      for (int k = 0; k < 5; k++) tick();
    end
    drain(40);
    tick();
    tick();
    check("frame_pulses", fd_q.size(), 2);
    if (fd_q.size() >= 1) check("frame1_at_beat", fd_q[0], 95);
    if (fd_q.size() >= 2) check("frame2_at_beat", fd_q[1], 190);
    check("frame_total_beats", hs_total, 190);
    check("frame_no_ovf", bus.overflow_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/deconv_col_packer.md
DECONV_COL_PACKER -- requirements
Module: deconv_col_packer

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8, output pixel width in bits; input lanes are 2*PIX_WIDTH wide.
REQ-002 SHALL have parameter N_PIX_OUT, default 19, pixels per deconvolved column and columns per output frame.
REQ-003 SHALL have parameter BEAT_PIX, default 4, pixels per output beat.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port col_valid_i, input, 1, one-cycle pulse marking a finished column on col_data_i.
REQ-007 SHALL have port col_data_i, input, 2*PIX_WIDTH*N_PIX_OUT, signed accumulated lanes; lane 0 is in the LSBs.
REQ-008 SHALL have port cfg_shift_i, input, 4, right-shift amount for requantisation, sampled on col_valid_i.
REQ-009 SHALL have port cfg_relu_i, input, 1, clamps negative results to 0 when high, sampled on col_valid_i.
REQ-010 SHALL have port m_valid_o, output, 1, output beat valid.
REQ-011 SHALL have port m_ready_i, input, 1, downstream ready.
REQ-012 SHALL have port m_data_o, output, BEAT_PIX*PIX_WIDTH, packed pixels; the lowest pixel index is in the LSBs.
REQ-013 SHALL have port m_keep_o, output, BEAT_PIX, per-pixel valid mask.
REQ-014 SHALL have port m_last_o, output, 1, last beat of a column.
REQ-015 SHALL have port frame_done_o, output, 1, one-cycle pulse after the last beat of column N_PIX_OUT-1 is accepted.
REQ-016 SHALL have port overflow_o, output, 1, sticky dropped-column flag.
REQ-017 SHALL have port ovf_clr_i, input, 1, clears overflow_o.

Function
REQ-018 SHALL requantise each lane as follows: arithmetic right shift by cfg_shift_i, adding 2^(cfg_shift_i-1) before the shift when cfg_shift_i>0; saturate to signed PIX_WIDTH, i.e. [-128,127] at default; then apply ReLU if enabled.
REQ-019 SHALL register the requantised column into a 2-entry column buffer one cycle after col_valid_i; there is no input backpressure.
REQ-020 SHALL drop a column and set overflow_o if col_valid_i arrives while both entries are occupied and no entry is released in that cycle.
REQ-021 SHALL treat an entry released by the final-beat handshake in a cycle as free for a col_valid_i in that same cycle, with no drop.
REQ-022 SHALL give ovf_clr_i and a new overflow in the same cycle the result overflow_o=1.
REQ-023 SHALL implement the FSM IDLE->LOAD->SEND->(LOAD if an entry is pending, else IDLE).
REQ-024 SHALL use LOAD for one cycle to select the oldest entry and reset the beat counter.
REQ-025 SHALL emit ceil(N_PIX_OUT/BEAT_PIX) beats per column in SEND, which is 5 at default.
REQ-026 SHALL achieve latency col_valid_i at cycle t -> first m_valid_o at t+2 when the block is idle.
REQ-027 SHALL hold m_data_o, m_keep_o and m_last_o stable while m_valid_o=1 and m_ready_i=0, and SHALL NOT drop m_valid_o before the handshake.
REQ-028 SHALL advance a beat only on m_valid_o & m_ready_i.
REQ-029 SHALL make m_keep_o all ones except on the last beat, where only the low N_PIX_OUT mod BEAT_PIX bits are set (0b0111 at default); unused lanes carry zero data.
REQ-030 SHALL count accepted columns 0..N_PIX_OUT-1, wrap to 0, and pulse frame_done_o one cycle after the wrapping final-beat handshake.
REQ-031 SHALL keep cfg values per buffered entry; a cfg change does not affect columns already buffered.

Reset
REQ-032 SHALL, while rst is high, force m_valid_o=0, m_data_o=0, m_keep_o=0, m_last_o=0, frame_done_o=0 and overflow_o=0.
REQ-033 SHALL, while rst is high, empty the buffer, zero the column and beat counters, and set the FSM to IDLE.
REQ-034 SHALL, on reset asserted mid-column, discard the partial column, and the next column after reset SHALL start at beat 0, column 0.

Verification
REQ-035 SHALL cover: all lanes 0x0100, shift 4, relu 0, m_ready_i=1 -> 5 beats of 0x10101010 from t+2 to t+6; beat 5 has keep 0b0111 and data 0x00101010 with m_last_o=1.
REQ-036 SHALL cover: lane values 0x7FFF, 0x8000 and 0xFFF8 with shift 3 -> pixels 0x7F, 0x80 and 0xFF; with relu=1 -> 0x7F, 0x00 and 0x00.
REQ-037 SHALL cover: m_ready_i low for 3 cycles mid-column -> the beat is held unchanged, with no missing or duplicated beats.
REQ-038 SHALL cover: 3 col_valid_i pulses 2 cycles apart with m_ready_i=0 -> the third is dropped, overflow_o=1 until ovf_clr_i, and exactly 2 columns are output later.
REQ-039 SHALL cover: 19 back-to-back columns -> frame_done_o pulses once after the 95th beat, and the column count restarts at 0.
REQ-040 SHALL cover: rst pulsed during beat 3 -> all outputs are 0 at once, and a column after reset emits a full 5 beats.
